// File: rtl/systolic_input_feeder.sv
// West-edge feeder for the systolic array.
// Vectors are buffered in a small FIFO and driven into the PE rows with a
// diagonal skew: row r sees a vector r cycles later than row 0. Each lane
// carries valid/switch tags next to its data, and batch_done marks the moment
// the last vector of a batch leaves the bottom row.
module systolic_input_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 2,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       in_switch,
  input  logic                       in_last,
  output logic [ROWS*DATA_WIDTH-1:0] west_input,
  output logic [ROWS-1:0]            west_valid,
  output logic [ROWS-1:0]            west_switch,
  output logic                       batch_done,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ROWS * DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // FIFO storage: each entry is {data, switch, last}
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full_s, empty_s, push_s, pop_s;
  logic [EW-1:0]              head_s;
  logic [ROWS*DATA_WIDTH-1:0] head_data_s;
  logic                       head_switch_s;
  logic                       head_last_s;

  // Skew stage tags: stage s holds the tags of the vector popped s edges ago
  logic [ROWS-1:0] tag_valid_q, tag_valid_d;
  logic [ROWS-1:0] tag_switch_q, tag_switch_d;
  logic [ROWS-1:0] tag_last_q, tag_last_d;

  // Data seen at stage r of lane r (the lane's tap point)
  logic [ROWS*DATA_WIDTH-1:0] lane_out_s;

  // Registered outputs
  logic [ROWS*DATA_WIDTH-1:0] west_input_q, west_input_d;
  logic [ROWS-1:0]            west_valid_q, west_valid_d;
  logic [ROWS-1:0]            west_switch_q, west_switch_d;
  logic                       batch_done_q, batch_done_d;

  assign full_s        = (count_q == CW'(DEPTH));
  assign empty_s       = (count_q == CW'(0));
  assign push_s        = in_valid & ~full_s;
  // No pops while the previous batch is still travelling through the skew
  assign pop_s         = (state_q != S_DRAIN) & ~empty_s;
  assign head_s        = mem_q[rd_ptr_q];
  assign head_data_s   = head_s[EW-1:2];
  assign head_switch_s = head_s[1];
  assign head_last_s   = head_s[0];

  // FIFO next-state: write on push, advance read pointer on pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {in_data, in_switch, in_last};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Batch FSM: a single-vector batch goes straight from IDLE to DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s && head_last_s) begin
          state_d = S_DRAIN;
        end else if (pop_s) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        if (pop_s && head_last_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (batch_done_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Tag shift chain: a popped entry enters stage 0, otherwise a bubble does
  always_comb begin
    tag_valid_d     = '0;
    tag_switch_d    = '0;
    tag_last_d      = '0;
    tag_valid_d[0]  = pop_s;
    tag_switch_d[0] = pop_s & head_switch_s;
    tag_last_d[0]   = pop_s & head_last_s;
    for (int s = 1; s < ROWS; s++) begin
      tag_valid_d[s]  = tag_valid_q[s-1];
      tag_switch_d[s] = tag_switch_q[s-1];
      tag_last_d[s]   = tag_last_q[s-1];
    end
  end

  // Tag stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q  <= '0;
      tag_switch_q <= '0;
      tag_last_q   <= '0;
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_switch_q <= tag_switch_d;
      tag_last_q   <= tag_last_d;
    end
  end

  // Per-lane data delay lines: lane r keeps r+1 stages of its own element
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_WIDTH-1:0] sd_q [r+1];
    logic [DATA_WIDTH-1:0] sd_d [r+1];

    // Load element r on a pop (zero on a bubble) and shift down the lane
    always_comb begin
      sd_d[0] = pop_s ? head_data_s[r*DATA_WIDTH +: DATA_WIDTH] : '0;
      for (int s = 1; s <= r; s++) begin
        sd_d[s] = sd_q[s-1];
      end
    end

    // Lane data stage registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= r; s++) begin
          sd_q[s] <= '0;
        end
      end else begin
        sd_q <= sd_d;
      end
    end

    assign lane_out_s[r*DATA_WIDTH +: DATA_WIDTH] = sd_q[r];
  end

  // Output stage: lane r taps stage r; data is zero whenever valid is low
  always_comb begin
    west_input_d  = '0;
    west_valid_d  = '0;
    west_switch_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      west_valid_d[r]  = tag_valid_q[r];
      west_switch_d[r] = tag_valid_q[r] & tag_switch_q[r];
      west_input_d[r*DATA_WIDTH +: DATA_WIDTH] =
        tag_valid_q[r] ? lane_out_s[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    batch_done_d = tag_valid_q[ROWS-1] & tag_last_q[ROWS-1];
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      west_input_q  <= '0;
      west_valid_q  <= '0;
      west_switch_q <= '0;
      batch_done_q  <= 1'b0;
    end else begin
      west_input_q  <= west_input_d;
      west_valid_q  <= west_valid_d;
      west_switch_q <= west_switch_d;
      batch_done_q  <= batch_done_d;
    end
  end

  assign in_ready    = ~full_s;
  assign west_input  = west_input_q;
  assign west_valid  = west_valid_q;
  assign west_switch = west_switch_q;
  assign batch_done  = batch_done_q;
  assign busy        = (state_q != S_IDLE) | ~empty_s | (|west_valid_q);

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Testbench for systolic_input_feeder: directed scenarios plus a random phase,
// all checked every cycle against a queue-based reference model.
module tb_systolic_input_feeder;

  localparam int DW    = 16;
  localparam int ROWS  = 2;
  localparam int DEPTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic                 in_switch;
  logic                 in_last;
  logic [ROWS*DW-1:0]   west_input;
  logic [ROWS-1:0]      west_valid;
  logic [ROWS-1:0]      west_switch;
  logic                 batch_done;
  logic                 busy;

  systolic_input_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_switch(in_switch), .in_last(in_last),
    .west_input(west_input), .west_valid(west_valid), .west_switch(west_switch),
    .batch_done(batch_done), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: FIFO as a queue, plus a history of what was popped
  // (or a bubble) at each recent edge. Row r shows the entry popped r+1
  // edges ago. After a last vector is popped, the next ROWS+1 edges pop nothing.
  typedef struct packed {
    logic [ROWS*DW-1:0] data;
    logic               sw;
    logic               last;
    logic               vld;
  } ent_t;

  ent_t q[$];
  ent_t hist [ROWS+1];
  int   drain_cnt;
  bit   in_batch;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int bd_cnt   = 0;
  bit full_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i <= ROWS; i++) hist[i] = '0;
    drain_cnt = 0;
    in_batch  = 1'b0;
  endtask

  task automatic check_outputs();
    logic [ROWS*DW-1:0] exp_d;
    logic [ROWS-1:0]    exp_v, exp_s;
    logic               any_v;
    exp_d = '0; exp_v = '0; exp_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      exp_v[r] = hist[r+1].vld;
      exp_s[r] = hist[r+1].vld & hist[r+1].sw;
      exp_d[r*DW +: DW] = hist[r+1].vld ? hist[r+1].data[r*DW +: DW] : '0;
    end
    any_v = |exp_v;
    chk("west_input",  west_input,  exp_d);
    chk("west_valid",  west_valid,  exp_v);
    chk("west_switch", west_switch, exp_s);
    chk("batch_done",  batch_done,  hist[ROWS].vld & hist[ROWS].last);
    chk("in_ready",    in_ready,    (q.size() < DEPTH));
    chk("busy",        busy,        in_batch || (q.size() > 0) || any_v);
    if (in_ready === 1'b0) full_seen = 1'b1;
    if (batch_done === 1'b1) bd_cnt++;
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge
  task automatic tick(input logic v, input logic [ROWS*DW-1:0] d,
                      input logic sw, input logic lst, output bit acc);
    bit   push, pop;
    ent_t e;
    in_valid = v; in_data = d; in_switch = sw; in_last = lst;
    push = v && (q.size() < DEPTH);
    pop  = (drain_cnt == 0) && (q.size() > 0);
    e = '0;
    if (pop) e = q.pop_front();
    if (push) q.push_back({d, sw, lst, 1'b1});
    for (int i = ROWS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = e;
    if (drain_cnt > 0) begin
      drain_cnt--;
      if (drain_cnt == 0) in_batch = 1'b0;
    end
    if (pop) begin
      in_batch = 1'b1;
      if (e.last) drain_cnt = ROWS + 1;
    end
    @(posedge clk);
    #1;
    check_outputs();
    acc = push;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  // Push one vector, holding it until accepted (bounded)
  task automatic push_vec(input logic [ROWS*DW-1:0] d, input logic sw, input logic lst);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      tick(1'b1, d, sw, lst, acc);
      tries++;
    end
    chk("push_accept_timeout", acc, 1'b1);
  endtask

  task automatic async_reset_check();
    in_valid = 1'b0; in_data = '0; in_switch = 1'b0; in_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_west_input",  west_input,  '0);
    chk("rst_west_valid",  west_valid,  '0);
    chk("rst_west_switch", west_switch, '0);
    chk("rst_batch_done",  batch_done,  1'b0);
    chk("rst_in_ready",    in_ready,    1'b1);
    chk("rst_busy",        busy,        1'b0);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_switch = 1'b0; in_last = 1'b0;
    model_reset();
    #12;
    chk("init_west_valid", west_valid, '0);
    chk("init_in_ready",   in_ready,   1'b1);
    chk("init_busy",       busy,       1'b0);
    #1 rst_n = 1'b1;

    // Single vector with switch and last: fixed latency anchors
    tick(1'b1, 32'h0200_0100, 1'b1, 1'b1, acc);  // edge k
    tick(1'b0, '0, 1'b0, 1'b0, acc);             // k+1
    tick(1'b0, '0, 1'b0, 1'b0, acc);             // k+2
    chk("t2_row0_data",   west_input[15:0], 16'h0100);
    chk("t2_row0_valid",  west_valid,       2'b01);
    chk("t2_row0_switch", west_switch,      2'b01);
    tick(1'b0, '0, 1'b0, 1'b0, acc);             // k+3
    chk("t2_row1_data",   west_input[31:16], 16'h0200);
    chk("t2_row1_valid",  west_valid,        2'b10);
    chk("t2_batch_done",  batch_done,        1'b1);
    tick(1'b0, '0, 1'b0, 1'b0, acc);             // k+4
    chk("t2_idle_busy",   busy,              1'b0);
    idle(2);

    // Four back-to-back vectors, one batch
    bd_cnt = 0;
    for (int i = 0; i < 4; i++) push_vec($urandom, (i == 0), (i == 3));
    idle(8);
    chk("t3_one_batch_done", bd_cnt, 1);

    // Bubble inside a batch
    push_vec($urandom, 1'b0, 1'b0);
    idle(2);
    push_vec($urandom, 1'b0, 1'b1);
    idle(7);

    // Backpressure: seven held vectors behind a draining batch
    full_seen = 1'b0;
    push_vec($urandom, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) push_vec($urandom, (i == 0), (i == 6));
    chk("t5_full_seen", full_seen, 1'b1);
    idle(14);

    // Batch A then batch B immediately
    push_vec($urandom, 1'b1, 1'b0);
    push_vec($urandom, 1'b0, 1'b1);
    push_vec($urandom, 1'b1, 1'b0);
    push_vec($urandom, 1'b0, 1'b1);
    idle(12);

    // Reset in the middle of a stream; nothing stale may appear afterwards
    push_vec($urandom, 1'b1, 1'b0);
    push_vec($urandom, 1'b0, 1'b0);
    push_vec($urandom, 1'b0, 1'b0);
    async_reset_check();
    idle(6);

    // Random traffic
    for (int i = 0; i < 120; i++) begin
      tick(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), acc);
    end
    idle(16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
